// File: rtl/fp16_mul_sched_if.sv
// Requester/consumer bundle for fp16_mul_sched: per-requester operand handshakes
// in, one ordered result stream out.
interface fp16_mul_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/fp16_mul_sched.sv
// Round-robin scheduler sharing one external fp16 multiplier among NREQ requesters;
// requester IDs ride a tag pipeline and results land in a credit-protected FWFT FIFO.
module fp16_mul_sched #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp16_mul_sched_if.slave      bus,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    output logic                 mul_valid,
    input  logic [15:0]          mul_result,
    output logic                 busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] cand;
    logic           found;
    logic           can_issue;
    logic           hs;
    logic           wr_en;
    logic           pop;

    logic [CW-1:0]  inflight;
    logic [CW-1:0]  count;
    logic [CW-1:0]  inflight_nxt;
    logic [CW-1:0]  count_nxt;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    logic [15:0]    a_arr [NREQ];
    logic [15:0]    b_arr [NREQ];

    logic           tag_v  [MUL_LAT+1];
    logic [IDW-1:0] tag_id [MUL_LAT+1];

    logic [IDW+15:0] mem [DEPTH];
    logic [IDW+15:0] head;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[16*i +: 16];
        assign b_arr[i] = bus.req_b[16*i +: 16];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Credit covers everything not yet popped, so the FIFO can never overflow.
    assign can_issue = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign hs        = rst_n & found & can_issue;

    always_comb begin
        bus.req_ready = '0;
        if (hs) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    assign wr_en         = tag_v[MUL_LAT];
    assign bus.rsp_valid = (count != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign inflight_nxt  = inflight + CW'(hs) - CW'(wr_en);
    assign count_nxt     = count + CW'(wr_en) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_valid <= 1'b0;
            inflight  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            busy      <= 1'b0;
            for (int unsigned k = 0; k < MUL_LAT + 1; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            mul_valid <= hs;
            if (hs) begin
                mul_a  <= a_arr[grant];
                mul_b  <= b_arr[grant];
                rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
            end
            tag_v[0]  <= hs;
            tag_id[0] <= grant;
            for (int unsigned k = 1; k < MUL_LAT + 1; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            inflight <= inflight_nxt;
            count    <= count_nxt;
            busy     <= (inflight_nxt != '0) || (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr] <= {tag_id[MUL_LAT], mul_result};
        end
    end

    // Head is forced to zero when empty so stale entries never show after reset.
    assign head         = mem[rd_ptr];
    assign bus.rsp_data = bus.rsp_valid ? head[15:0] : '0;
    assign bus.rsp_id   = bus.rsp_valid ? head[IDW+15:16] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
endmodule
